// File: rtl/rob_commit_unit_pkg.sv
// Shared Tomasulo definitions for the reorder buffer and reservation-station logic.
// Holds the default sizing of the reorder buffer and the per-entry state encoding.
package rob_commit_unit_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_DATA_W = 16;
  localparam int ROB_REG_W  = 4;

  typedef enum logic [1:0] {
    ENT_FREE   = 2'd0,
    ENT_ISSUED = 2'd1,
    ENT_DONE   = 2'd2
  } ent_state_e;

endpackage

// File: rtl/rob_entry_array.sv
// Reorder-buffer entry storage: per-entry state, destination register and result.
// Ports:
//   clock, reset           - clock and synchronous active-high reset
//   flush                  - frees every entry
//   alloc_en/idx/dest      - marks entry idx ISSUED with its destination
//   cdb_valid/tag/data     - result broadcast; written only into an ISSUED entry
//   retire_en              - frees the entry at head_idx
//   head_idx               - entry presented on head_state/head_dest/head_data
module rob_entry_array
  import rob_commit_unit_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = ROB_DATA_W,
  parameter int REG_W  = ROB_REG_W,
  parameter int TAG_W  = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc_en,
  input  logic [TAG_W-1:0]  alloc_idx,
  input  logic [REG_W-1:0]  alloc_dest,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              retire_en,
  input  logic [TAG_W-1:0]  head_idx,
  output ent_state_e        head_state,
  output logic [REG_W-1:0]  head_dest,
  output logic [DATA_W-1:0] head_data
);

  ent_state_e        state_q [DEPTH];
  ent_state_e        state_d [DEPTH];
  logic [REG_W-1:0]  dest_q  [DEPTH];
  logic [REG_W-1:0]  dest_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];

  // A freshly allocated entry is still FREE when sampled, so a broadcast to the
  // tag being allocated in the same cycle never lands. Allocation and retirement
  // can never address the same entry: that needs head == tail with count in (0, DEPTH).
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    data_d  = data_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alloc_en && (alloc_idx == TAG_W'(i))) begin
        state_d[i] = ENT_ISSUED;
        dest_d[i]  = alloc_dest;
      end else if (retire_en && (head_idx == TAG_W'(i))) begin
        state_d[i] = ENT_FREE;
      end else if (cdb_valid && (cdb_tag == TAG_W'(i)) && (state_q[i] == ENT_ISSUED)) begin
        state_d[i] = ENT_DONE;
        data_d[i]  = cdb_data;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) state_q[i] <= ENT_FREE;
    end else begin
      state_q <= state_d;
    end
    dest_q <= dest_d;
    data_q <= data_d;
  end

  assign head_state = state_q[head_idx];
  assign head_dest  = dest_q[head_idx];
  assign head_data  = data_q[head_idx];

endmodule

// File: rtl/rob_commit_unit.sv
// In-order commit unit of a reorder buffer.
// Ports:
//   clock, reset                       - clock and synchronous active-high reset
//   alloc_valid/alloc_dest             - issue request and its destination register
//   alloc_ready/alloc_tag              - space available / tag granted (tail pointer)
//   cdb_valid/cdb_tag/cdb_data         - common-data-bus result broadcast
//   flush                              - discards every entry
//   commit_valid/dest/data/tag         - registered one-cycle retirement report
//   count/empty                        - occupancy
module rob_commit_unit
  import rob_commit_unit_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int DATA_W = ROB_DATA_W,
  parameter int REG_W  = ROB_REG_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       alloc_valid,
  input  logic [REG_W-1:0]           alloc_dest,
  output logic                       alloc_ready,
  output logic [$clog2(DEPTH)-1:0]   alloc_tag,
  input  logic                       cdb_valid,
  input  logic [$clog2(DEPTH)-1:0]   cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  input  logic                       flush,
  output logic                       commit_valid,
  output logic [REG_W-1:0]           commit_dest,
  output logic [DATA_W-1:0]          commit_data,
  output logic [$clog2(DEPTH)-1:0]   commit_tag,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int TAG_W = $clog2(DEPTH);
  localparam int CNT_W = TAG_W + 1;

  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  ent_state_e        head_state;
  logic [REG_W-1:0]  head_dest;
  logic [DATA_W-1:0] head_data;
  logic              alloc_acc, cdb_hits_head, retire_now;
  logic [DATA_W-1:0] retire_data;

  logic              vld_p1;
  logic [REG_W-1:0]  dest_p1;
  logic [DATA_W-1:0] data_p1;
  logic [TAG_W-1:0]  tag_p1;

  rob_entry_array #(
    .DEPTH (DEPTH),
    .DATA_W(DATA_W),
    .REG_W (REG_W),
    .TAG_W (TAG_W)
  ) u_entries (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .alloc_en  (alloc_acc),
    .alloc_idx (tail_q),
    .alloc_dest(alloc_dest),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .retire_en (retire_now),
    .head_idx  (head_q),
    .head_state(head_state),
    .head_dest (head_dest),
    .head_data (head_data)
  );

  // Ready comes from the registered count only, so a full buffer refuses an
  // allocation even in the cycle it retires.
  assign alloc_ready = (count_q < CNT_W'(DEPTH));
  assign alloc_acc   = alloc_valid && alloc_ready && !flush;

  // A broadcast that completes the head retires it in the same cycle, using the
  // bus data directly, so the commit appears one cycle after the broadcast.
  assign cdb_hits_head = cdb_valid && (cdb_tag == head_q) && (head_state == ENT_ISSUED);
  assign retire_now    = !flush && ((head_state == ENT_DONE) || cdb_hits_head);
  assign retire_data   = (head_state == ENT_DONE) ? head_data : cdb_data;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(alloc_acc) - CNT_W'(retire_now);
    if (retire_now) head_d = head_q + TAG_W'(1);
    if (alloc_acc)  tail_d = tail_q + TAG_W'(1);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // ---- stage p1: registered commit report ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1  <= 1'b0;
      dest_p1 <= '0;
      data_p1 <= '0;
      tag_p1  <= '0;
    end else begin
      vld_p1 <= retire_now;
      if (retire_now) begin
        dest_p1 <= head_dest;
        data_p1 <= retire_data;
        tag_p1  <= head_q;
      end
    end
  end

  assign commit_valid = vld_p1;
  assign commit_dest  = dest_p1;
  assign commit_data  = data_p1;
  assign commit_tag   = tag_p1;
  assign alloc_tag    = tail_q;
  assign count        = count_q;
  assign empty        = (count_q == '0);

endmodule
